pairwise_divider: RTL
=====================

Name: pairwise_divider

Overview:
- Sequential radix-4 restoring divider and the inverse of the team's pairwise pipelined multiplier. It takes an 8-bit product-width dividend and a 4-bit divisor and returns an 8-bit quotient and a 4-bit remainder.
- It retires two dividend bits per cycle, i.e. one bit pair per iteration.
- It sits beside the multiplier in the arithmetic datapath and is used to check and invert multiplier results.
- Start/busy/done handshake; outputs are registered and held.

Parameters:
- DW, 8, dividend and quotient width; must be even; iteration count is DW/2.
- VW, 4, divisor and remainder width.

Ports:
- clk1  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  DW  unsigned dividend; sampled with start.
- divisor  in  VW  unsigned divisor; sampled with start.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse when results are written.
- quotient  out  DW  unsigned quotient; held until the next completion.
- remainder  out  VW  unsigned remainder; held until the next completion.
- div_by_zero  out  1  set with done if the divisor was 0; held with the results.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and working registers cleared.
  - An in-flight operation is discarded with no done pulse.
- States: IDLE, RUN.
- IDLE:
  - At a rising edge with start=1, latch dividend into a working shift register and divisor into a divisor register.
  - Clear the partial remainder (VW bits) and counter; state<=RUN, busy<=1.
  - start=0 keeps state IDLE.
- RUN: one iteration per rising edge, DW/2 iterations.
  - Form t = {partial_remainder, top two working-dividend bits} (VW+2 bits), then shift the working dividend left by 2.
  - Digit k = largest of 3,2,1,0 with k*divisor <= t. Compare against divisor, 2*divisor, 3*divisor computed at VW+2 bits, with no truncation.
  - partial_remainder <= t - k*divisor (always < divisor, so it fits in VW bits).
  - Working quotient <= {working_quotient[DW-3:0], k}.
- Completion, on the edge of iteration DW/2:
  - quotient<=final quotient, remainder<=final partial remainder, done<=1, busy<=0, state<=IDLE.
  - done deasserts on the next edge.
- Latency: start sampled at edge N gives done high from edge N+DW/2 until edge N+DW/2+1 (4 cycles for DW=8).
  - Back-to-back: the next start is accepted at edge N+DW/2+1.
- start while busy is ignored: no effect on the operation, operands or outputs.
- dividend and divisor may change freely after the start edge.
- Divide by zero (latched divisor == 0):
  - Same timing as a normal division.
  - At completion: quotient=all ones, remainder=0, div_by_zero=1.
- div_by_zero clears at the next normal completion.
- quotient, remainder and div_by_zero change only at completion or reset; they never show intermediate values.
- Invariant for divisor != 0: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Reset, then start with dividend=143, divisor=11 -> after 4 cycles done pulses once; quotient=13, remainder=0, div_by_zero=0, busy low.
- 200/7 followed immediately by 255/1 (start re-asserted the cycle after done) -> first result q=28, r=4; second result q=255, r=0 exactly 4 cycles later.
- 9/15 -> q=0, r=9. Then 225/15 -> q=15, r=0. Then a random exhaustive sweep over all 256x15 nonzero-divisor pairs checked against a model.
- 77/0 -> q=8'hFF, r=0, div_by_zero=1 at the normal latency. Then 10/3 -> q=3, r=1, div_by_zero=0.
- Start 100/3; pulse start with 50/5 on the 2nd RUN cycle -> done once, q=33, r=1, second request dropped.
- Start 100/3; assert rst asynchronously (mid-cycle) on the 2nd RUN cycle -> all outputs 0 immediately, no done. After release, 60/4 -> q=15, r=0.

Source files
------------

// File: rtl/pairwise_divider_if.sv
// Handshake and operand/result bundle for the pairwise radix-4 divider.
interface pairwise_divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  // Requester side: drives the request and operands, observes results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/pairwise_divider.sv
// Sequential radix-4 restoring divider: retires one dividend bit pair per
// cycle, producing a DW-bit quotient and VW-bit remainder after DW/2 cycles.
// Results are registered and held until the next completion.
module pairwise_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic              clk1,
  input  logic              rst,
  pairwise_divider_if.slave bus
);

  localparam int ITER = DW / 2;
  localparam int CW   = $clog2(ITER) + 1;
  localparam int TW   = VW + 2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_load;
  logic            w_iter;
  logic            w_finish;

  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_work;
  logic [DW-3:0]   r_quo;
  logic [VW-1:0]   r_prem;
  logic [VW-1:0]   r_div;

  logic            r_busy;
  logic            r_done;
  logic [DW-1:0]   r_q;
  logic [VW-1:0]   r_r;
  logic            r_dbz;

  logic [TW-1:0]   w_t;
  logic [TW-1:0]   w_d1;
  logic [TW-1:0]   w_d2;
  logic [TW-1:0]   w_d3;
  logic [1:0]      w_k;
  logic [VW-1:0]   w_kd;
  logic [VW-1:0]   w_rem;
  logic [DW-1:0]   w_quo_nxt;
  logic            w_last;

  // Trial value: partial remainder with the next two dividend bits appended.
  assign w_t  = {r_prem, r_work[DW-1:DW-2]};
  // Divisor multiples at full TW width so 3*divisor never truncates.
  assign w_d1 = {2'b00, r_div};
  assign w_d2 = {1'b0, r_div, 1'b0};
  assign w_d3 = w_d1 + w_d2;

  // Digit select: largest k in 0..3 with k*divisor <= t.
  always_comb begin
    w_k  = 2'd0;
    w_kd = '0;
    if (w_t >= w_d3) begin
      w_k  = 2'd3;
      w_kd = w_d3[VW-1:0];
    end else if (w_t >= w_d2) begin
      w_k  = 2'd2;
      w_kd = w_d2[VW-1:0];
    end else if (w_t >= w_d1) begin
      w_k  = 2'd1;
      w_kd = w_d1[VW-1:0];
    end
  end

  // The true difference is below the divisor, so the low VW bits are exact.
  assign w_rem     = w_t[VW-1:0] - w_kd;
  assign w_quo_nxt = {r_quo, w_k};
  assign w_last    = (r_cnt == CW'(ITER - 1));

  // Next-state and control decode for the IDLE/RUN sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_iter      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_iter = 1'b1;
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Working registers, iteration counter and held result registers.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_work <= '0;
      r_quo  <= '0;
      r_prem <= '0;
      r_div  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_work <= bus.dividend;
        r_div  <= bus.divisor;
        r_prem <= '0;
        r_quo  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (w_iter) begin
        r_work <= {r_work[DW-3:0], 2'b00};
        r_prem <= w_rem;
        r_quo  <= w_quo_nxt[DW-3:0];
        r_cnt  <= r_cnt + 1'b1;
        if (w_finish) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_div == '0) begin
            r_q   <= '1;
            r_r   <= '0;
            r_dbz <= 1'b1;
          end else begin
            r_q   <= w_quo_nxt;
            r_r   <= w_rem;
            r_dbz <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_q;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = r_dbz;

endmodule
